// File: rtl/fwd_hazard_ctrl.sv
// EX-stage operand-forwarding and hazard control.
// Tracks the instruction in EX (P1), raises registered forward flags and a
// registered forward value for the instruction leaving ID, and stalls for a
// single cycle when forwarding cannot cover the dependency (load-use, or an
// rd2 dependency when op2 is the immediate).
module fwd_hazard_ctrl #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_alu_src,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_reg_write,
  input  logic             id_is_load,
  input  logic             id_is_jump,
  input  logic [XLEN-1:0]  ex_alu_res,
  input  logic [XLEN-1:0]  ex_write_data,
  input  logic             flush,
  output logic             stall,
  output logic             ex_valid,
  output logic             fwd_a,
  output logic             fwd_b,
  output logic [XLEN-1:0]  fwd_res,
  output logic [CNT_W-1:0] stall_count
);

  // EX-slot record of the instruction issued last cycle
  logic            p1_valid;
  logic [RA_W-1:0] p1_rd;
  logic            p1_wr;
  logic            p1_load;
  logic            p1_jump;

  logic hit1;
  logic hit2;
  logic issue;
  logic fwd_a_nxt;
  logic fwd_b_nxt;

  // Dependency detection, stall and next forward flags
  always_comb begin
    hit1      = p1_valid & p1_wr & (p1_rd != '0) & (p1_rd == id_rs1);
    hit2      = p1_valid & p1_wr & (p1_rd != '0) & (p1_rd == id_rs2);
    stall     = id_valid & ~flush &
                ((id_use_rs1 & hit1 & p1_load) |
                 (id_use_rs2 & hit2 & (p1_load | id_alu_src)));
    issue     = id_valid & ~flush & ~stall;
    fwd_a_nxt = issue & id_use_rs1 & hit1 & ~p1_load;
    // EX gives fwd_b priority over alu_src, so never forward into an immediate op2
    fwd_b_nxt = issue & id_use_rs2 & ~id_alu_src & hit2 & ~p1_load;
  end

  assign ex_valid = p1_valid;

  // EX-slot tracking, registered forward outputs and stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_valid    <= 1'b0;
      p1_rd       <= '0;
      p1_wr       <= 1'b0;
      p1_load     <= 1'b0;
      p1_jump     <= 1'b0;
      fwd_a       <= 1'b0;
      fwd_b       <= 1'b0;
      fwd_res     <= '0;
      stall_count <= '0;
    end else begin
      p1_valid <= issue;
      if (issue) begin
        p1_rd   <= id_rd;
        p1_wr   <= id_reg_write;
        p1_load <= id_is_load;
        p1_jump <= id_is_jump;
      end
      fwd_a <= fwd_a_nxt;
      fwd_b <= fwd_b_nxt;
      if (fwd_a_nxt | fwd_b_nxt)
        fwd_res <= p1_jump ? ex_write_data : ex_alu_res;
      if (stall && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: table-driven producer/consumer
// pairs, hand-written multi-cycle sequences and a randomized run against a
// reference model of "the instruction currently in EX".
module tb_fwd_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2, id_alu_src;
  logic        id_reg_write, id_is_load, id_is_jump;
  logic [31:0] ex_alu_res, ex_write_data;
  logic        flush;
  logic        stall, ex_valid, fwd_a, fwd_b;
  logic [31:0] fwd_res;
  logic [15:0] stall_count;
  logic        stall_s, ex_valid_s, fwd_a_s, fwd_b_s;
  logic [31:0] fwd_res_s;
  logic [3:0]  stall_count_s;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.XLEN(32), .RA_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_alu_src(id_alu_src),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .id_is_jump(id_is_jump), .ex_alu_res(ex_alu_res), .ex_write_data(ex_write_data),
    .flush(flush), .stall(stall), .ex_valid(ex_valid), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .fwd_res(fwd_res), .stall_count(stall_count)
  );

  // Narrow counter instance so saturation is reachable in a short run
  fwd_hazard_ctrl #(.XLEN(32), .RA_W(5), .CNT_W(4)) u_small (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_alu_src(id_alu_src),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .id_is_jump(id_is_jump), .ex_alu_res(ex_alu_res), .ex_write_data(ex_write_data),
    .flush(flush), .stall(stall_s), .ex_valid(ex_valid_s), .fwd_a(fwd_a_s), .fwd_b(fwd_b_s),
    .fwd_res(fwd_res_s), .stall_count(stall_count_s)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit       valid;
    bit [4:0] rd;
    bit       wr;
    bit       load;
    bit       jump;
  } instr_t;

  instr_t      m_ex;
  bit          m_fa, m_fb;
  bit [31:0]   m_res;
  int unsigned m_cnt;

  // Does the instruction in EX produce the value of register r?
  function automatic bit produced_by_ex(input logic [4:0] r);
    return m_ex.valid && m_ex.wr && (r != 0) && (r == m_ex.rd);
  endfunction

  function automatic bit model_stall();
    bit need1, need2;
    if (!id_valid || flush) return 0;
    need1 = id_use_rs1 && produced_by_ex(id_rs1);
    need2 = id_use_rs2 && produced_by_ex(id_rs2);
    // a load result is not ready in EX; an immediate op2 leaves no bypass for rd2
    return (need1 && m_ex.load) || (need2 && (m_ex.load || id_alu_src));
  endfunction

  task automatic model_edge();
    bit st, iss, fa, fb;
    if (rst) begin
      m_ex = '{default: 0};
      m_fa = 0; m_fb = 0; m_res = 0; m_cnt = 0;
      return;
    end
    st  = model_stall();
    iss = id_valid && !flush && !st;
    fa  = iss && id_use_rs1 && produced_by_ex(id_rs1) && !m_ex.load;
    fb  = iss && id_use_rs2 && !id_alu_src && produced_by_ex(id_rs2) && !m_ex.load;
    if (fa || fb) m_res = m_ex.jump ? ex_write_data : ex_alu_res;
    if (st && m_cnt < 65535) m_cnt++;
    m_fa = fa; m_fb = fb;
    if (iss) m_ex = '{valid: 1, rd: id_rd, wr: id_reg_write, load: id_is_load, jump: id_is_jump};
    else     m_ex.valid = 0;
  endtask

  // One clock: check comb stall, advance model, check registered outputs
  task automatic tick();
    #1;
    chk("stall", {31'b0, stall}, {31'b0, model_stall()});
    model_edge();
    @(posedge clk);
    #1;
    chk("ex_valid", {31'b0, ex_valid}, {31'b0, m_ex.valid});
    chk("fwd_a", {31'b0, fwd_a}, {31'b0, m_fa});
    chk("fwd_b", {31'b0, fwd_b}, {31'b0, m_fb});
    chk("fwd_res", fwd_res, m_res);
    chk("stall_count", {16'b0, stall_count}, m_cnt);
    chk("stall_count_sat4", {28'b0, stall_count_s}, (m_cnt > 15) ? 32'd15 : m_cnt);
  endtask

  task automatic set_id(input bit v, input bit [4:0] rs1, input bit [4:0] rs2,
                        input bit u1, input bit u2, input bit asrc, input bit [4:0] rd,
                        input bit wr, input bit ld, input bit jmp);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_alu_src = asrc; id_rd = rd; id_reg_write = wr; id_is_load = ld; id_is_jump = jmp;
  endtask

  task automatic idle(); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask

  // Issue a producer writing rd (no source operands) after a bubble
  task automatic produce(input bit [4:0] rd, input bit wr, input bit ld, input bit jmp);
    idle(); flush = 0; tick();
    set_id(1, 0, 0, 0, 0, 0, rd, wr, ld, jmp); tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string     name;
    bit [4:0]  p_rd; bit p_wr; bit p_ld; bit p_jmp;
    bit [31:0] alu;  bit [31:0] wd;
    bit [4:0]  rs1;  bit [4:0] rs2; bit u1; bit u2; bit asrc;
    bit        e_stall; bit e_fa; bit e_fb; bit [31:0] e_res;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{"alu_raw",    5'd5, 1, 0, 0, 32'h11,       32'h99, 5'd5, 5'd0, 1, 0, 0, 0, 1, 0, 32'h11};
    vecs[1] = '{"x0_dest",    5'd0, 1, 0, 0, 32'hDEADBEEF, 32'h0,  5'd0, 5'd0, 1, 1, 0, 0, 0, 0, 32'h11};
    vecs[2] = '{"jump_link",  5'd1, 1, 0, 1, 32'h55,       32'hA,  5'd1, 5'd1, 1, 1, 0, 0, 1, 1, 32'hA};
    vecs[3] = '{"load_use",   5'd7, 1, 1, 0, 32'h77,       32'h0,  5'd0, 5'd7, 0, 1, 0, 1, 0, 0, 32'hA};
    vecs[4] = '{"store_data", 5'd3, 1, 0, 0, 32'h33,       32'h0,  5'd3, 5'd3, 1, 1, 1, 1, 0, 0, 32'hA};
    vecs[5] = '{"imm_rs1",    5'd4, 1, 0, 0, 32'h44,       32'h0,  5'd4, 5'd9, 1, 1, 1, 0, 1, 0, 32'h44};
    vecs[6] = '{"no_write",   5'd6, 0, 0, 0, 32'h66,       32'h0,  5'd6, 5'd0, 1, 0, 0, 0, 0, 0, 32'h44};
    vecs[7] = '{"unused_src", 5'd8, 1, 1, 0, 32'h88,       32'h0,  5'd8, 5'd8, 0, 0, 0, 0, 0, 0, 32'h44};
    vecs[8] = '{"rs2_fwd",    5'd2, 1, 0, 0, 32'h22,       32'h0,  5'd0, 5'd2, 0, 1, 0, 0, 0, 1, 32'h22};
  end

  initial begin
    bit held;
    rst = 1; flush = 0; ex_alu_res = 0; ex_write_data = 0; idle();
    tick();
    chk("reset_ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("reset_fwd_res", fwd_res, 32'd0);
    chk("reset_count", {16'b0, stall_count}, 32'd0);
    rst = 0;

    // table-driven producer/consumer pairs
    for (int i = 0; i < 9; i++) begin
      produce(vecs[i].p_rd, vecs[i].p_wr, vecs[i].p_ld, vecs[i].p_jmp);
      ex_alu_res = vecs[i].alu; ex_write_data = vecs[i].wd;
      set_id(1, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].asrc, 5'd10, 1, 0, 0);
      #1;
      chk({vecs[i].name, "_stall"}, {31'b0, stall}, {31'b0, vecs[i].e_stall});
      tick();
      chk({vecs[i].name, "_fwd_a"}, {31'b0, fwd_a}, {31'b0, vecs[i].e_fa});
      chk({vecs[i].name, "_fwd_b"}, {31'b0, fwd_b}, {31'b0, vecs[i].e_fb});
      chk({vecs[i].name, "_fwd_res"}, fwd_res, vecs[i].e_res);
    end

    // load-use: one stall, bubble, then issue without forwarding
    rst = 1; idle(); tick(); rst = 0;
    produce(5'd7, 1, 1, 0);
    set_id(1, 5'd0, 5'd7, 0, 1, 0, 5'd11, 1, 0, 0);
    #1; chk("lu_stall", {31'b0, stall}, 32'd1);
    tick();
    chk("lu_bubble", {31'b0, ex_valid}, 32'd0);
    chk("lu_count", {16'b0, stall_count}, 32'd1);
    #1; chk("lu_stall_released", {31'b0, stall}, 32'd0);
    tick();
    chk("lu_issue_valid", {31'b0, ex_valid}, 32'd1);
    chk("lu_issue_fwd_b", {31'b0, fwd_b}, 32'd0);

    // store-data with immediate op2: stall, then no forwards at all
    produce(5'd3, 1, 0, 0);
    set_id(1, 5'd3, 5'd3, 1, 1, 1, 5'd12, 1, 0, 0);
    #1; chk("sd_stall", {31'b0, stall}, 32'd1);
    tick(); tick();
    chk("sd_fwd_a", {31'b0, fwd_a}, 32'd0);
    chk("sd_fwd_b", {31'b0, fwd_b}, 32'd0);
    chk("sd_valid", {31'b0, ex_valid}, 32'd1);

    // flush beats a load-use stall and is not counted
    produce(5'd7, 1, 1, 0);
    set_id(1, 5'd7, 5'd0, 1, 0, 0, 5'd13, 1, 0, 0);
    flush = 1;
    #1; chk("fl_stall", {31'b0, stall}, 32'd0);
    tick();
    chk("fl_valid", {31'b0, ex_valid}, 32'd0);
    chk("fl_count", {16'b0, stall_count}, 32'd2);
    flush = 0;

    // reset during a stall cycle; held consumer then reissues unforwarded
    produce(5'd9, 1, 0, 0);
    ex_alu_res = 32'h1234;
    set_id(1, 5'd9, 5'd0, 1, 0, 0, 5'd7, 1, 1, 0); tick();
    chk("rs_pre_fwd_res", fwd_res, 32'h1234);
    set_id(1, 5'd7, 5'd0, 1, 0, 0, 5'd14, 1, 0, 0);
    #1; chk("rs_stall", {31'b0, stall}, 32'd1);
    rst = 1; tick(); rst = 0;
    chk("rs_valid", {31'b0, ex_valid}, 32'd0);
    chk("rs_fwd_res", fwd_res, 32'd0);
    chk("rs_count", {16'b0, stall_count}, 32'd0);
    #1; chk("rs_stall_after", {31'b0, stall}, 32'd0);
    tick();
    chk("rs_reissue_valid", {31'b0, ex_valid}, 32'd1);
    chk("rs_reissue_fwd_a", {31'b0, fwd_a}, 32'd0);

    // randomized run; a stalled ID instruction is held
    held = 0;
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 7) == 0);
      ex_alu_res = $urandom; ex_write_data = $urandom;
      if (!held)
        set_id($urandom_range(0, 5) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 3)),
               ($urandom_range(0, 4) != 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0));
      #1; held = model_stall() && !rst;
      tick();
    end
    chk("small_saturated", {28'b0, stall_count_s}, (m_cnt > 15) ? 32'd15 : m_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
